// File: rtl/din_debouncer.sv
// din_debouncer
//   Debounces a raw push-button level. A change is accepted only after
//   STABLE_CNT consecutive samples at the new level. Each accepted press
//   produces a single-cycle pulse on din_pulse and increments press_cnt.
//
// Parameters
//   CNT_W      width of the stability counter
//   STABLE_CNT consecutive stable samples needed to accept a change
//              (1 .. 2**CNT_W)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   btn_in     raw, possibly bouncing button level
//   din_pulse  registered one-cycle pulse per accepted press
//   level      registered debounced level
//   press_cnt  registered count of accepted presses (wraps 255 -> 0)
//   p_state    present FSM state, for debug
//
// Build option
//   DIN_SYNC_EN  when defined, btn_in passes through a 2-flop synchronizer
//                before the FSM, adding 2 cycles to every latency.
module din_debouncer #(
  parameter int CNT_W      = 4,
  parameter int STABLE_CNT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       din_pulse,
  output logic       level,
  output logic [7:0] press_cnt,
  output logic [1:0] p_state
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    HOLD_HI = 2'b10,
    WAIT_LO = 2'b11
  } state_t;

  // Counter value on the last sample of a stable run.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic samp;

`ifdef DIN_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = btn_in;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             din_pulse_q, din_pulse_d;
  logic             level_q, level_d;
  logic [7:0]       press_cnt_q, press_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE_LO;
      cnt_q       <= '0;
      din_pulse_q <= 1'b0;
      level_q     <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      din_pulse_q <= din_pulse_d;
      level_q     <= level_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    din_pulse_d = 1'b0;
    press_cnt_d = press_cnt_q;

    case (state_q)
      IDLE_LO: begin
        if (samp) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!samp) begin
          // Bounce back low: drop the pending press silently.
          state_d = IDLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = HOLD_HI;
          din_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD_HI: begin
        if (!samp) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (samp) begin
          // Release bounce: still pressed, and no new pulse.
          state_d = HOLD_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase

    if (din_pulse_d) begin
      press_cnt_d = press_cnt_q + 8'd1;
    end

    // Registered from the next state so level rises with din_pulse.
    level_d = (state_d == HOLD_HI) || (state_d == WAIT_LO);
  end

  assign din_pulse = din_pulse_q;
  assign level     = level_q;
  assign press_cnt = press_cnt_q;
  assign p_state   = state_q;

endmodule

// File: tb/tb_din_debouncer.sv
// tb_din_debouncer
//   Directed bench for din_debouncer with STABLE_CNT=4. Inputs are changed
//   1 time unit after a rising edge and outputs are checked at that same
//   point, so each check sees the result of the edge just taken.
module tb_din_debouncer;

  localparam int CNT_W      = 4;
  localparam int STABLE_CNT = 4;
`ifdef DIN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  // Edges of stable input needed before an accepted change is visible.
  localparam int ACC = STABLE_CNT + 1 + LAT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_in = 1'b0;
  logic       din_pulse;
  logic       level;
  logic [7:0] press_cnt;
  logic [1:0] p_state;

  int errors = 0;
  int checks = 0;

  din_debouncer #(
    .CNT_W     (CNT_W),
    .STABLE_CNT(STABLE_CNT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .din_pulse(din_pulse),
    .level    (level),
    .press_cnt(press_cnt),
    .p_state  (p_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    int bounce[8];

    // Reset state
    rst = 1'b0;
    btn_in = 1'b0;
    tick();
    tick();
    check("rst_state", {6'd0, p_state}, 8'd0);
    check("rst_level", {7'd0, level}, 8'd0);
    check("rst_pulse", {7'd0, din_pulse}, 8'd0);
    check("rst_cnt", press_cnt, 8'd0);
    rst = 1'b1;
    tick();
    check("idle_state", {6'd0, p_state}, 8'd0);
    $display("reset: state=%0d level=%0d cnt=%0d", p_state, level, press_cnt);

    // Clean press: pulse only after the ACC-th edge, level high from then on
    btn_in = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("press_pulse", {7'd0, din_pulse}, (i == ACC) ? 8'd1 : 8'd0);
      check("press_level", {7'd0, level}, (i >= ACC) ? 8'd1 : 8'd0);
    end
    check("press_cnt1", press_cnt, 8'd1);
    check("press_hold", {6'd0, p_state}, 8'd2);
    $display("clean press: level=%0d cnt=%0d", level, press_cnt);

    // Clean release
    btn_in = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("rel_level", {7'd0, level}, (i < ACC) ? 8'd1 : 8'd0);
      check("rel_pulse", {7'd0, din_pulse}, 8'd0);
    end
    check("rel_idle", {6'd0, p_state}, 8'd0);
    $display("clean release: level=%0d", level);

    // Press bounce: 1,1,1,0,1,1,1 then low
    bounce = '{1, 1, 1, 0, 1, 1, 1, 0};
    for (int i = 0; i < 16; i++) begin
      btn_in = (i < 8) ? bounce[i][0] : 1'b0;
      tick();
      check("pb_pulse", {7'd0, din_pulse}, 8'd0);
      check("pb_level", {7'd0, level}, 8'd0);
    end
    check("pb_cnt", press_cnt, 8'd1);
    $display("press bounce: level=%0d cnt=%0d", level, press_cnt);

    // Release bounce: accepted press, low 2 cycles, back high, then real release
    btn_in = 1'b1;
    for (int i = 1; i <= 12; i++) tick();
    check("rb_press_cnt", press_cnt, 8'd2);
    btn_in = 1'b0;
    tick();
    tick();
    btn_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("rb_level", {7'd0, level}, 8'd1);
      check("rb_pulse", {7'd0, din_pulse}, 8'd0);
    end
    btn_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("rb_fall", {7'd0, level}, (i < ACC) ? 8'd1 : 8'd0);
    end
    check("rb_cnt", press_cnt, 8'd2);
    $display("release bounce: level=%0d cnt=%0d", level, press_cnt);

    // Mid-operation reset with cnt=2 in WAIT_HI, button held high
    btn_in = 1'b1;
    for (int i = 1; i <= 3 + LAT; i++) begin
      tick();
      check("mr_nopulse", {7'd0, din_pulse}, 8'd0);
    end
    check("mr_wait_hi", {6'd0, p_state}, 8'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mr_state", {6'd0, p_state}, 8'd0);
    check("mr_pulse", {7'd0, din_pulse}, 8'd0);
    check("mr_cnt0", press_cnt, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("mr_after", {7'd0, din_pulse}, (i == ACC) ? 8'd1 : 8'd0);
      check("mr_level", {7'd0, level}, (i >= ACC) ? 8'd1 : 8'd0);
    end
    check("mr_cnt1", press_cnt, 8'd1);
    $display("mid reset: level=%0d cnt=%0d", level, press_cnt);

    // Wrap: reset, then 256 minimum-spaced presses
    rst = 1'b0;
    btn_in = 1'b0;
    tick();
    rst = 1'b1;
    check("wr_cnt0", press_cnt, 8'd0);
    pulses = 0;
    for (int p = 1; p <= 256; p++) begin
      int this_press;
      this_press = 0;
      btn_in = 1'b1;
      for (int i = 0; i < ACC; i++) begin
        tick();
        if (din_pulse) this_press++;
      end
      btn_in = 1'b0;
      for (int i = 0; i < ACC; i++) begin
        tick();
        if (din_pulse) this_press++;
      end
      pulses += this_press;
      if (this_press != 1) check("wr_one_pulse", 8'(this_press), 8'd1);
      if (p == 255) check("wr_cnt255", press_cnt, 8'd255);
    end
    check("wr_pulses_lo", 8'(pulses), 8'(256));
    check("wr_pulses_hi", 8'(pulses >> 8), 8'd1);
    check("wr_cnt_wrap", press_cnt, 8'd0);
    check("wr_level", {7'd0, level}, 8'd0);
    $display("wrap: pulses=%0d cnt=%0d", pulses, press_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/din_debouncer.md
DIN_DEBOUNCER -- requirements
Module: din_debouncer

Interface
REQ-001 The module SHALL have parameter CNT_W, default 4, giving the width of the stability counter.
REQ-002 The module SHALL have parameter STABLE_CNT, default 10, giving the consecutive stable samples required to accept a level change; legal range 1..2^CNT_W.
REQ-003 Port clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-low.
REQ-005 Port btn_in  input  1  raw, possibly bouncing push-button level.
REQ-006 Port din_pulse  output  1  registered single-cycle pulse per accepted press; drives a downstream toggle FSM's din.
REQ-007 Port level  output  1  registered debounced level.
REQ-008 Port press_cnt  output  8  registered count of accepted presses.
REQ-009 Port p_state  output  2  present FSM state, for debug.

Function
REQ-010 samp SHALL be the sampled input: btn_in directly, or the synchronizer output per REQ-028.
REQ-011 The FSM SHALL have states IDLE_LO=2'b00, WAIT_HI=2'b01, HOLD_HI=2'b10 and WAIT_LO=2'b11, with a CNT_W-bit counter cnt.
REQ-012 In IDLE_LO: samp=1 SHALL move to WAIT_HI with cnt=0; samp=0 SHALL hold the state.
REQ-013 In WAIT_HI: samp=0 SHALL return to IDLE_LO; samp=1 with cnt==STABLE_CNT-1 SHALL move to HOLD_HI; otherwise cnt SHALL increment.
REQ-014 In HOLD_HI: samp=0 SHALL move to WAIT_LO with cnt=0; samp=1 SHALL hold the state.
REQ-015 In WAIT_LO: samp=1 SHALL return to HOLD_HI with no pulse; samp=0 with cnt==STABLE_CNT-1 SHALL move to IDLE_LO; otherwise cnt SHALL increment.
REQ-016 din_pulse SHALL be 1 for exactly the one cycle following the WAIT_HI->HOLD_HI transition, and 0 at all other times.
REQ-017 Latency: with samp=1 on STABLE_CNT+1 consecutive edges starting in IDLE_LO, din_pulse SHALL be high after the (STABLE_CNT+1)th edge.
REQ-018 level SHALL be 1 exactly when the registered state is HOLD_HI or WAIT_LO; it rises in the same cycle as din_pulse.
REQ-019 press_cnt SHALL increment by 1 on each WAIT_HI->HOLD_HI transition and wrap 255->0.
REQ-020 Any samp change during WAIT_HI or WAIT_LO SHALL abort the wait, producing no pulse and no level change.
REQ-021 An illegal state is unreachable with 2 bits; a default branch SHALL nevertheless go to IDLE_LO.
REQ-022 Back-to-back presses SHALL each produce a separate pulse; the minimum spacing between pulses is 2*STABLE_CNT+2 cycles.

Reset
REQ-023 While rst=0 at a clock edge: state SHALL go to IDLE_LO, and cnt, din_pulse, level and press_cnt SHALL go to 0.
REQ-024 Synchronizer flops, when present, SHALL also reset to 0.
REQ-025 Reset during WAIT_HI SHALL discard the pending press, with no pulse.
REQ-026 Reset during HOLD_HI SHALL clear level immediately.
REQ-027 A button held high through reset release SHALL be debounced afresh and SHALL yield one pulse per REQ-017.

Configuration
REQ-028 With macro DIN_SYNC_EN defined, samp SHALL come from a 2-flop synchronizer on btn_in, adding exactly 2 cycles to every latency.
REQ-029 With DIN_SYNC_EN undefined, samp SHALL equal btn_in, with no added latency.

Verification (STABLE_CNT=4, DIN_SYNC_EN undefined unless stated)
REQ-030 Clean press: btn_in 0->1 held 12 cycles -> din_pulse=1 for one cycle after the 5th edge sampling 1; level=1 from that cycle; press_cnt=1.
REQ-031 Press bounce: btn_in 1 for 3 cycles, 0 for 1, 1 for 3, then 0 -> din_pulse never 1; level stays 0; press_cnt=0.
REQ-032 Release bounce: after an accepted press, btn_in 0 for 2 cycles, back to 1 -> level stays 1 with no second pulse; then btn_in 0 -> level=0 after the 5th edge sampling 0.
REQ-033 Wrap: 256 clean presses -> 256 single pulses; press_cnt=0 after the last.
REQ-034 Mid-operation reset: rst=0 for 1 cycle when cnt=2 in WAIT_HI, btn_in held 1 -> no pulse then; a pulse 5 edges after rst returns to 1; press_cnt=1.
REQ-035 DIN_SYNC_EN defined, clean press -> din_pulse after the 7th edge from the first btn_in=1 sample.
